// File: rtl/array_mult_arbiter_if.sv
// Bundles the two requester channels, the multiplier operand/product wires and
// the tagged response channel of array_mult_arbiter.
interface array_mult_arbiter_if #(
  parameter int WIDTH = 6
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_m;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_m;
  logic               busy;

  // Environment side: requesters, the multiplier instance and the consumer.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_m, rsp_ready,
    input  req0_ready, req1_ready, mul_a, mul_b,
    input  rsp_valid, rsp_id, rsp_m, busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_m, rsp_ready,
    output req0_ready, req1_ready, mul_a, mul_b,
    output rsp_valid, rsp_id, rsp_m, busy
  );
endinterface

// File: rtl/array_mult_arbiter.sv
// array_mult_arbiter: round-robin share of one combinational WIDTHxWIDTH
// multiplier between two requesters. The granted operands are registered onto
// the multiplier inputs, the product is captured after LAT settle cycles and
// returned on a valid/ready channel tagged with the owning requester.
module array_mult_arbiter #(
  parameter int WIDTH = 6,
  parameter int LAT   = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  array_mult_arbiter_if.slave bus
);

  localparam int               CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] rsp_m_q, rsp_m_d;
  logic               rsp_id_q, rsp_id_d;
  logic               rsp_valid_q, rsp_valid_d;

  logic grant0, grant1;
  logic accept0, accept1;

  // Arbitration, next-state and register update values for the whole block.
  always_comb begin
    // The requester that did not win last time wins a tie.
    grant0  = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    // Readys are suppressed while reset is held so nothing is handed over
    // that the reset edge would then throw away.
    accept0 = rst_n && (state_q == IDLE) && grant0;
    accept1 = rst_n && (state_q == IDLE) && grant1;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_m_d      = rsp_m_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (accept0 || accept1) begin
          mul_a_d      = accept1 ? bus.req1_a : bus.req0_a;
          mul_b_d      = accept1 ? bus.req1_b : bus.req0_b;
          rsp_id_d     = accept1;
          last_grant_d = accept1;
          cnt_d        = CNT_LOAD;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_m_d     = bus.mul_m;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // No accept in this cycle: the arbiter only grants from IDLE.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, product, tag and round-robin registers; operands are held after
  // completion and only change on accept or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_m_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_m_q      <= rsp_m_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.rsp_m      = rsp_m_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_array_mult_arbiter.sv
// Bench for array_mult_arbiter: one LAT=1 and one LAT=3 instance share the
// requester/consumer stimulus; each has its own behavioural multiplier.
module tb_array_mult_arbiter;
  localparam int W  = 6;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         r0v, r1v, rspr;
  logic [W-1:0] r0a, r0b, r1a, r1b;

  array_mult_arbiter_if #(.WIDTH(W)) if1 ();
  array_mult_arbiter_if #(.WIDTH(W)) if3 ();

  assign if1.req0_valid = r0v;
  assign if1.req0_a     = r0a;
  assign if1.req0_b     = r0b;
  assign if1.req1_valid = r1v;
  assign if1.req1_a     = r1a;
  assign if1.req1_b     = r1b;
  assign if1.rsp_ready  = rspr;
  assign if1.mul_m      = PW'(if1.mul_a) * PW'(if1.mul_b);

  assign if3.req0_valid = r0v;
  assign if3.req0_a     = r0a;
  assign if3.req0_b     = r0b;
  assign if3.req1_valid = r1v;
  assign if3.req1_a     = r1a;
  assign if3.req1_b     = r1b;
  assign if3.rsp_ready  = rspr;
  assign if3.mul_m      = PW'(if3.mul_a) * PW'(if3.mul_b);

  array_mult_arbiter #(.WIDTH(W), .LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  array_mult_arbiter #(.WIDTH(W), .LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit id;
    int a;
    int b;
    int m;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r0v = 1'b0; r1v = 1'b0; rspr = 1'b1;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // One lone request on the LAT=1 instance with the consumer always ready.
  task automatic txn1(input bit id, input int a, input int b, input int m, input string tag);
    int n;
    rspr = 1'b1;
    r0v  = (id == 1'b0);
    r1v  = (id == 1'b1);
    if (id) begin r1a = W'(a); r1b = W'(b); end
    else    begin r0a = W'(a); r0b = W'(b); end
    #1;
    chk({tag, " ready"}, 32'(id ? if1.req1_ready : if1.req0_ready), 1);
    chk({tag, " other ready"}, 32'(id ? if1.req0_ready : if1.req1_ready), 0);
    step();
    r0v = 1'b0; r1v = 1'b0;
    chk({tag, " mul_a"}, 32'(if1.mul_a), a);
    chk({tag, " mul_b"}, 32'(if1.mul_b), b);
    chk({tag, " busy"}, 32'(if1.busy), 1);
    n = 0;
    while (!if1.rsp_valid && n < 20) begin step(); n++; end
    // Valid rises LAT edges after the accepting edge.
    chk({tag, " latency"}, n, 1);
    chk({tag, " rsp_m"}, 32'(if1.rsp_m), m);
    chk({tag, " rsp_id"}, 32'(if1.rsp_id), 32'(id));
    step();
    chk({tag, " rsp_valid drop"}, 32'(if1.rsp_valid), 0);
  endtask

  // Both requesters valid on the LAT=1 instance; collects the id order of n
  // responses (bit i = id of the i-th response).
  task automatic both_run(input int n, input bit hold, input logic [7:0] exp_ids, input string tag);
    int          got;
    int          cyc;
    bit          overlap;
    logic [7:0]  ids;
    int          exp_m;
    bit          exp_id;
    bit          acc0, acc1;
    got = 0; cyc = 0; overlap = 1'b0; ids = '0; exp_m = 0; exp_id = 1'b0;
    rspr = 1'b1;
    r0v = 1'b1; r1v = 1'b1;
    while (got < n && cyc < 100) begin
      #1;
      if (if1.req0_ready && if1.req1_ready) overlap = 1'b1;
      acc0 = if1.req0_ready;
      acc1 = if1.req1_ready;
      if (acc0) begin exp_id = 1'b0; exp_m = int'(r0a) * int'(r0b); end
      if (acc1) begin exp_id = 1'b1; exp_m = int'(r1a) * int'(r1b); end
      if (if1.rsp_valid) begin
        chk({tag, " rsp_id"}, 32'(if1.rsp_id), 32'(exp_id));
        chk({tag, " rsp_m"}, 32'(if1.rsp_m), exp_m);
        ids[got] = if1.rsp_id;
        got++;
      end
      step();
      cyc++;
      if (!hold && acc0) r0v = 1'b0;
      if (!hold && acc1) r1v = 1'b0;
    end
    r0v = 1'b0; r1v = 1'b0;
    chk({tag, " responses"}, got, n);
    chk({tag, " readys overlap"}, 32'(overlap), 0);
    chk({tag, " id order"}, 32'(ids & 8'((1 << n) - 1)), 32'(exp_ids));
  endtask

  initial begin : main
    int  n;
    bit  stale;
    bit  pend0, pend1, outst, mlast, e0, e1, vis, exp_id;
    int  due, cyc, done, exp_m;

    vecs[0] = '{1'b0, 63, 63, 3969};
    vecs[1] = '{1'b1,  0, 42,    0};
    vecs[2] = '{1'b0,  5,  7,   35};
    vecs[3] = '{1'b1,  9,  3,   27};
    vecs[4] = '{1'b1, 63,  1,   63};
    vecs[5] = '{1'b0, 32,  2,   64};

    // Reset with both requesters already asserting.
    rst_n = 1'b0; rspr = 1'b1;
    r0v = 1'b1; r0a = 6'd5; r0b = 6'd7;
    r1v = 1'b1; r1a = 6'd9; r1b = 6'd3;
    step(); step();
    chk("reset req0_ready", 32'(if1.req0_ready), 0);
    chk("reset req1_ready", 32'(if1.req1_ready), 0);
    chk("reset rsp_valid", 32'(if1.rsp_valid), 0);
    chk("reset busy", 32'(if1.busy), 0);
    chk("reset mul_a", 32'(if1.mul_a), 0);
    chk("reset mul_b", 32'(if1.mul_b), 0);
    chk("reset rsp_m", 32'(if1.rsp_m), 0);
    chk("reset rsp_id", 32'(if1.rsp_id), 0);

    // Tie straight out of reset: r0 first, then r1.
    rst_n = 1'b1;
    both_run(2, 1'b0, 8'b10, "tie");

    // Continuous contention alternates 0,1,0,1.
    r0a = 6'd12; r0b = 6'd11; r1a = 6'd60; r1b = 6'd50;
    both_run(4, 1'b1, 8'b1010, "alt");

    // Table of single transactions.
    for (int i = 0; i < 6; i++)
      txn1(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].m, $sformatf("vec%0d", i));

    // Back-pressured response holds; a waiting req0 is not granted meanwhile.
    rspr = 1'b0; r1v = 1'b1; r1a = 6'd0; r1b = 6'd42;
    #1;
    chk("bp req1_ready", 32'(if1.req1_ready), 1);
    step();
    r1v = 1'b0; r0v = 1'b1; r0a = 6'd1; r0b = 6'd1;
    n = 0;
    while (!if1.rsp_valid && n < 20) begin step(); n++; end
    chk("bp latency", n, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp rsp_valid", 32'(if1.rsp_valid), 1);
      chk("bp rsp_m", 32'(if1.rsp_m), 0);
      chk("bp rsp_id", 32'(if1.rsp_id), 1);
      chk("bp req0 held off", 32'(if1.req0_ready), 0);
      step();
    end
    rspr = 1'b1;
    #1;
    chk("bp no ready in handshake cycle", 32'(if1.req0_ready), 0);
    step();
    chk("bp req0_ready after handshake", 32'(if1.req0_ready), 1);
    step();
    r0v = 1'b0;
    n = 0;
    while (!if1.rsp_valid && n < 20) begin step(); n++; end
    chk("bp second rsp_m", 32'(if1.rsp_m), 1);
    chk("bp second rsp_id", 32'(if1.rsp_id), 0);
    step();

    // Reset while waiting on the multiplier.
    r1v = 1'b1; r1a = 6'd5; r1b = 6'd5;
    #1;
    chk("midrst ready", 32'(if1.req1_ready), 1);
    step();
    r1v = 1'b0;
    chk("midrst mul_a loaded", 32'(if1.mul_a), 5);
    rst_n = 1'b0;
    step();
    r0v = 1'b1;
    #1;
    chk("midrst rsp_valid", 32'(if1.rsp_valid), 0);
    chk("midrst busy", 32'(if1.busy), 0);
    chk("midrst mul_a", 32'(if1.mul_a), 0);
    chk("midrst no ready in reset", 32'(if1.req0_ready), 0);
    r0v = 1'b0;
    rst_n = 1'b1; rspr = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (if1.rsp_valid) stale = 1'b1;
    end
    chk("midrst stale response", 32'(stale), 0);

    // LAT=3 instance: valid appears in the fourth cycle counting the accept
    // cycle, i.e. three edges after the accepting edge.
    do_reset();
    r0v = 1'b1; r0a = 6'd1; r0b = 6'd63;
    #1;
    chk("lat3 ready", 32'(if3.req0_ready), 1);
    step();
    r0v = 1'b0;
    n = 0;
    while (!if3.rsp_valid && n < 20) begin step(); n++; end
    chk("lat3 latency", n, 3);
    chk("lat3 rsp_m", 32'(if3.rsp_m), 63);
    chk("lat3 rsp_id", 32'(if3.rsp_id), 0);
    step();
    chk("lat3 rsp_valid drop", 32'(if3.rsp_valid), 0);

    // Random traffic on the LAT=3 instance against a cycle-count model:
    // one job outstanding at most, result due LAT edges after the grant.
    do_reset();
    pend0 = 1'b0; pend1 = 1'b0; outst = 1'b0; mlast = 1'b1;
    due = 0; cyc = 0; done = 0; exp_m = 0; exp_id = 1'b0;
    while (done < 1000 && cyc < 40000) begin
      if (!pend0 && ($urandom % 4 != 0)) begin
        pend0 = 1'b1; r0a = W'($urandom); r0b = W'($urandom);
      end
      if (!pend1 && ($urandom % 4 != 0)) begin
        pend1 = 1'b1; r1a = W'($urandom); r1b = W'($urandom);
      end
      r0v  = pend0;
      r1v  = pend1;
      rspr = 1'($urandom % 2);
      #1;
      e0  = !outst && pend0 && (!pend1 || mlast);
      e1  = !outst && pend1 && (!pend0 || !mlast);
      vis = outst && (cyc >= due);
      chk("rnd req0_ready", 32'(if3.req0_ready), 32'(e0));
      chk("rnd req1_ready", 32'(if3.req1_ready), 32'(e1));
      chk("rnd rsp_valid", 32'(if3.rsp_valid), 32'(vis));
      if (vis) begin
        chk("rnd rsp_m", 32'(if3.rsp_m), exp_m);
        chk("rnd rsp_id", 32'(if3.rsp_id), 32'(exp_id));
      end
      step();
      cyc++;
      if (vis && rspr) begin
        outst = 1'b0;
        done++;
      end
      if (e0 || e1) begin
        outst  = 1'b1;
        due    = cyc + 3;
        exp_id = e1;
        mlast  = e1;
        exp_m  = e1 ? int'(r1a) * int'(r1b) : int'(r0a) * int'(r0b);
        if (e1) pend1 = 1'b0;
        else    pend0 = 1'b0;
      end
    end
    r0v = 1'b0; r1v = 1'b0;
    chk("rnd completed products", done, 1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
